// File: rtl/bullet_pkg.sv
// Shared bullet word layout for the bullet table and the VGA display
// controller's pixel-overlap check.
//
// Word layout (32 bits per slot):
//   [31:23] X   top-left corner
//   [22:14] Y   top-left corner
//   [12:11] direction
//   [5]     active
//   all other bits are zero
package bullet_pkg;

  localparam int X_HI       = 31;
  localparam int X_LO       = 23;
  localparam int Y_HI       = 22;
  localparam int Y_LO       = 14;
  localparam int DIR_HI     = 12;
  localparam int DIR_LO     = 11;
  localparam int ACTIVE_BIT = 5;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int BULLET_SIZE = 12;
  localparam int MAX_BULLETS = 64;

  // Build an active bullet word; every unused bit is left at zero.
  function automatic logic [31:0] packWord(input logic [8:0] x,
                                           input logic [8:0] y,
                                           input logic [1:0] dir);
    logic [31:0] w;
    w                 = '0;
    w[X_HI:X_LO]      = x;
    w[Y_HI:Y_LO]      = y;
    w[DIR_HI:DIR_LO]  = dir;
    w[ACTIVE_BIT]     = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/bullet_step.sv
// Combinational one-frame advance of a single bullet word.
//
// Ports:
//   word_in   bullet word before the move
//   word_out  bullet word after the move (all zero when retired)
//   retired   high when an active bullet leaves the legal area
//
// Arithmetic is done in 10 bits so that X/Y + SPEED never wraps. A word
// whose position already lies outside X_MAX/Y_MAX (spawned out of range)
// is retired on its first step regardless of direction.
module bullet_step
  import bullet_pkg::*;
#(
  parameter int SPEED = 4,
  parameter int X_MAX = 499,
  parameter int Y_MAX = 467
) (
  input  logic [31:0] word_in,
  output logic [31:0] word_out,
  output logic        retired
);

  logic [9:0] x10;
  logic [9:0] y10;
  logic [8:0] nextX;
  logic [8:0] nextY;
  logic [1:0] dir;
  logic       edgeHit;
  logic       outOfRange;

  always_comb begin
    x10     = {1'b0, word_in[X_HI:X_LO]};
    y10     = {1'b0, word_in[Y_HI:Y_LO]};
    dir     = word_in[DIR_HI:DIR_LO];
    nextX   = word_in[X_HI:X_LO];
    nextY   = word_in[Y_HI:Y_LO];
    edgeHit = 1'b0;

    case (dir)
      DIR_UP: begin
        if (y10 < 10'(SPEED)) edgeHit = 1'b1;
        else                  nextY   = 9'(y10 - 10'(SPEED));
      end
      DIR_DOWN: begin
        if (y10 + 10'(SPEED) > 10'(Y_MAX)) edgeHit = 1'b1;
        else                               nextY   = 9'(y10 + 10'(SPEED));
      end
      DIR_RIGHT: begin
        if (x10 + 10'(SPEED) > 10'(X_MAX)) edgeHit = 1'b1;
        else                               nextX   = 9'(x10 + 10'(SPEED));
      end
      default: begin
        if (x10 < 10'(SPEED)) edgeHit = 1'b1;
        else                  nextX   = 9'(x10 - 10'(SPEED));
      end
    endcase

    outOfRange = (x10 > 10'(X_MAX)) || (y10 > 10'(Y_MAX));

    // Inactive slots pass through untouched.
    retired  = 1'b0;
    word_out = word_in;
    if (word_in[ACTIVE_BIT]) begin
      if (edgeHit || outOfRange) begin
        retired  = 1'b1;
        word_out = '0;
      end else begin
        word_out = packWord(nextX, nextY, dir);
      end
    end
  end

endmodule

// File: rtl/bullet_manager.sv
// Live bullet table: spawns bullets on fire requests, advances every slot
// once per frame tick (one slot per clock) and retires bullets at the edges.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   frame_tick     one-cycle end-of-frame pulse (display screenEnd)
//   fire           one-cycle spawn request, samples spawn_x/y/dir
//   spawn_x/y      spawn position
//   spawn_dir      0 up, 1 down, 2 right, 3 left
//   all_bullets    packed table, slot i at [i*32 +: 32]
//   busy           high while a frame scan runs (MAX_BULLETS cycles)
//   active_count   number of active slots
//   spawn_dropped  one-cycle pulse when a spawn request is discarded
//
// Optional build macro BULLET_COOLDOWN_EN: adds a frame-based cooldown that
// rejects fire requests for COOLDOWN_FRAMES frame ticks after each accepted one.
module bullet_manager
  import bullet_pkg::*;
#(
  parameter int MAX_BULLETS     = 64,
  parameter int SPEED           = 4,
  parameter int X_MAX           = 499,
  parameter int Y_MAX           = 467,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     fire,
  input  logic [8:0]               spawn_x,
  input  logic [8:0]               spawn_y,
  input  logic [1:0]               spawn_dir,
  output logic [32*MAX_BULLETS-1:0] all_bullets,
  output logic                     busy,
  output logic [6:0]               active_count,
  output logic                     spawn_dropped
);

  localparam int IDX_W = $clog2(MAX_BULLETS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_SPAWN = 2'd2;

  logic [1:0]                    state;
  logic [IDX_W-1:0]              idx;
  logic [MAX_BULLETS-1:0][31:0]  slots;
  logic                          tickPend;
  logic                          spawnPend;
  logic [8:0]                    pendX;
  logic [8:0]                    pendY;
  logic [1:0]                    pendDir;
  logic [31:0]                   stepOut;
  logic                          stepRetired;
  logic [IDX_W-1:0]              freeIdx;
  logic                          freeFound;
  logic                          coolBlock;
  logic                          fireAccept;
  logic                          fireReject;

  assign all_bullets = slots;
  assign busy        = (state == ST_SCAN);

  assign fireAccept = fire && !spawnPend && !coolBlock;
  assign fireReject = fire && !fireAccept;

`ifdef BULLET_COOLDOWN_EN
  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
  logic [CD_W-1:0] coolCnt;

  assign coolBlock = (coolCnt != '0);

  // Reload wins over a simultaneous frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coolCnt <= '0;
    end else if (fireAccept) begin
      coolCnt <= CD_W'(COOLDOWN_FRAMES);
    end else if (frame_tick && coolBlock) begin
      coolCnt <= coolCnt - 1'b1;
    end
  end
`else
  // No cooldown gate in this build; the expression is constant false.
  assign coolBlock = (COOLDOWN_FRAMES < 0);
`endif

  bullet_step #(
    .SPEED (SPEED),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) stepUnit (
    .word_in  (slots[idx]),
    .word_out (stepOut),
    .retired  (stepRetired)
  );

  // Lowest free slot: scan from the top so the lowest index wins.
  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
      if (!slots[i][ACTIVE_BIT]) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
    end
  end

  // Request latching: runs in every state. A new tick always wins over the
  // IDLE clear so back-to-back ticks are never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tickPend  <= 1'b0;
      spawnPend <= 1'b0;
      pendX     <= '0;
      pendY     <= '0;
      pendDir   <= '0;
    end else begin
      if (frame_tick)            tickPend <= 1'b1;
      else if (state == ST_IDLE) tickPend <= 1'b0;

      if (fireAccept) begin
        spawnPend <= 1'b1;
        pendX     <= spawn_x;
        pendY     <= spawn_y;
        pendDir   <= spawn_dir;
      end else if (state == ST_SPAWN) begin
        spawnPend <= 1'b0;
      end
    end
  end

  // Table FSM: one slot written per clock in SCAN, one slot in SPAWN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      slots         <= '0;
      active_count  <= '0;
      spawn_dropped <= 1'b0;
    end else begin
      spawn_dropped <= fireReject || ((state == ST_SPAWN) && !freeFound);

      case (state)
        ST_IDLE: begin
          if (tickPend) begin
            state <= ST_SCAN;
            idx   <= '0;
          end else if (spawnPend) begin
            state <= ST_SPAWN;
          end
        end

        ST_SCAN: begin
          slots[idx] <= stepOut;
          if (stepRetired) active_count <= active_count - 7'd1;
          idx <= idx + 1'b1;
          if (idx == IDX_W'(MAX_BULLETS - 1)) state <= ST_IDLE;
        end

        ST_SPAWN: begin
          if (freeFound) begin
            slots[freeIdx] <= packWord(pendX, pendY, pendDir);
            active_count   <= active_count + 7'd1;
          end
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bullet_manager.md
Name: bullet_manager

Overview:
- Owns the live bullet table: spawns bullets on fire requests, advances them once per frame, retires them at screen edges.
- Sits directly upstream of the VGA display controller; drives its packed bullet bus (MAX_BULLETS x 32-bit words) consumed by the pixel-overlap check.
- Table is registered state; one slot is updated per clock during a frame scan, so per-frame work is MAX_BULLETS cycles.

Parameters:
- MAX_BULLETS, 64, number of bullet slots (power of two).
- SPEED, 4, pixels moved per frame tick.
- X_MAX, 499, largest legal bullet X (top-left corner).
- Y_MAX, 467, largest legal bullet Y (480 - 12 - 1).
- COOLDOWN_FRAMES, 8, minimum frame ticks between accepted spawns (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at end of frame (the display's screenEnd)
- fire  in  1  one-cycle spawn request
- spawn_x  in  9  spawn X, sampled with fire
- spawn_y  in  9  spawn Y, sampled with fire
- spawn_dir  in  2  0 = up, 1 = down, 2 = right, 3 = left
- all_bullets  out  32*MAX_BULLETS  slot i at bits [i*32 +: 32]
- busy  out  1  high while a frame scan is in progress
- active_count  out  7  number of active slots
- spawn_dropped  out  1  one-cycle pulse when a request is discarded

Behaviour:
- Word format:
  - [31:23] X
  - [22:14] Y
  - [12:11] dir
  - [5] active
  - all other bits 0
- Reset (asynchronous, active-high): all_bullets = 0, busy = 0, active_count = 0, spawn_dropped = 0, FSM = IDLE, pending flags cleared.
- Request latching (any state):
  - frame_tick sets tick_pend.
  - fire sets spawn_pend and latches x/y/dir, but only if spawn_pend is clear.
  - fire while spawn_pend is already set is ignored and pulses spawn_dropped.
- FSM states: IDLE, SCAN, SPAWN.
- IDLE:
  - If tick_pend: clear it, idx = 0, go to SCAN. Tick has priority over a spawn.
  - Else if spawn_pend: go to SPAWN.
- SCAN:
  - Each cycle rewrite slot idx with its step result; idx++.
  - After idx = MAX_BULLETS-1, return to IDLE.
  - busy = 1 throughout SCAN; a scan takes exactly MAX_BULLETS cycles.
- Step rule (10-bit arithmetic, no wrap):
  - Inactive slot: unchanged.
  - up: Y < SPEED -> retire, else Y - SPEED.
  - down: Y + SPEED > Y_MAX -> retire, else Y + SPEED.
  - right: X + SPEED > X_MAX -> retire, else X + SPEED.
  - left: X < SPEED -> retire, else X - SPEED.
  - Retire = whole word zeroed.
- SPAWN:
  - Priority-encode the lowest slot with active = 0 and write {x, y, dir, active = 1}.
  - If no slot is free: pulse spawn_dropped and write nothing.
  - Clear spawn_pend; return to IDLE.
- Latency:
  - fire sampled at edge t -> word visible on all_bullets after edge t+2 (when idle with no pending tick).
  - frame_tick sampled at edge t -> slot i updated at edge t+2+i.
- A frame_tick during SCAN is latched and runs another scan afterwards. A fire during SCAN waits until the scan ends.
- Spawn at an out-of-range position is accepted as-is; it is retired on the next step.
- active_count is registered: it increments on a spawn, decrements on a retire, and never changes both in one cycle.

Optional Feature:
- Macro: BULLET_COOLDOWN_EN.
- Defined:
  - A frame counter reloads to COOLDOWN_FRAMES on each accepted spawn and decrements on each frame_tick, saturating at 0.
  - fire while the counter is nonzero is discarded and pulses spawn_dropped.
- Undefined: no counter; every fire is subject only to the pending and full rules.

Decomposition:
- Shared package (bullet_pkg):
  - field position constants: X_HI/LO, Y_HI/LO, DIR_HI/LO, ACTIVE_BIT
  - dir encoding constants
  - BULLET_SIZE = 12, MAX_BULLETS
  - the display controller imports the same field constants.
- Sub-module bullet_step: purely combinational word_in -> word_out and retired flag, parameterised by SPEED, X_MAX, Y_MAX; instantiated once and muxed by idx.

Test Plan:
- Reset mid-scan (assert reset when idx = 30) -> all_bullets = 0, busy = 0, active_count = 0 immediately, with no clock edge needed.
- fire x=100, y=200, dir=right; then frame_tick -> slot 0 = X 100, Y 200, active; after the scan X = 104; busy high for exactly 64 cycles.
- Spawn y=2, dir=up; frame_tick -> slot retired (word 0); active_count goes 1 -> 0.
- 65 fires spaced 3 cycles apart -> slots 0..63 active; 65th pulses spawn_dropped; active_count = 64.
- fire and frame_tick in the same cycle with one existing bullet -> scan completes first; new bullet lands in slot 1, not moved this frame.
- BULLET_COOLDOWN_EN defined, COOLDOWN_FRAMES = 8: second fire after 3 ticks is dropped; fire after 8 ticks is accepted.
